// File: rtl/instr_fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
package instr_fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    StBoot,
    StFetch,
    StDrain
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO holding fetched {pc, instr} pairs for the decode stage.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  input  logic                           flush,
  output logic [WIDTH-1:0]               head_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rptr_q, wptr_q;
  logic [CW-1:0]    count_q;
  logic             push_en, pop_en;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign pop_en  = pop && !empty;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign push_en = push && (!full || pop_en);

  assign head_data = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (push_en && !flush) begin
      mem_q[wptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_en) wptr_q <= wptr_q + PW'(1);
      if (pop_en)  rptr_q <= rptr_q + PW'(1);
      count_q <= count_q + CW'(push_en) - CW'(pop_en);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: credit-limited request issue, in-order response capture and
// redirect handling that drains responses belonging to the abandoned stream.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned     BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic [XLEN-1:0] iaddr,
  output logic            ireq,
  input  logic            igrant,
  input  logic            irvalid,
  input  logic [XLEN-1:0] irdata,
  input  logic            redir_valid,
  input  logic [XLEN-1:0] redir_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc
);

  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned PW = $clog2(BUF_DEPTH);
  localparam logic [CW:0] BufDepthC = (CW+1)'(BUF_DEPTH);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   outstanding_q, discard_q;
  logic [XLEN-1:0] pcq_mem_q [BUF_DEPTH];
  logic [PW-1:0]   pcq_wptr_q, pcq_rptr_q;

  logic            req_fire, rsp_fire, rsp_keep, fifo_pop;
  logic [CW-1:0]   outstanding_after;
  logic [CW:0]     credit_used;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [2*XLEN-1:0] fifo_head;

  assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign ireq        = (state_q == StFetch) && !redir_valid && (credit_used < BufDepthC);
  assign iaddr       = pc_q;
  assign req_fire    = ireq && igrant;

  // Stray responses with nothing outstanding are ignored entirely.
  assign rsp_fire          = irvalid && (outstanding_q != '0);
  assign rsp_keep          = rsp_fire && (state_q == StFetch) && !redir_valid;
  assign outstanding_after = outstanding_q - CW'(rsp_fire);

  assign out_valid = !fifo_empty && !redir_valid;
  assign fifo_pop  = out_valid && out_ready;
  assign out_instr = fifo_empty ? NOP_INSTR : fifo_head[XLEN-1:0];
  assign out_pc    = fifo_empty ? '0 : fifo_head[2*XLEN-1:XLEN];

  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (2 * XLEN)
  ) u_fetch_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (rsp_keep),
    .push_data ({pcq_mem_q[pcq_rptr_q], irdata}),
    .pop       (fifo_pop),
    .flush     (redir_valid),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // PC queue of issued requests; every counted response consumes one entry.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      pcq_mem_q[pcq_wptr_q] <= pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StBoot;
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      pcq_wptr_q    <= '0;
      pcq_rptr_q    <= '0;
    end else begin
      if (req_fire) pcq_wptr_q <= pcq_wptr_q + PW'(1);
      if (rsp_fire) pcq_rptr_q <= pcq_rptr_q + PW'(1);
      outstanding_q <= outstanding_after + CW'(req_fire);

      if (redir_valid) begin
        // Everything still in flight belongs to the old stream.
        pc_q      <= {redir_pc[XLEN-1:2], 2'b00};
        discard_q <= outstanding_after;
        state_q   <= (outstanding_after != '0) ? StDrain : StFetch;
      end else begin
        if (req_fire) pc_q <= pc_q + 32'd4;
        unique case (state_q)
          StBoot:  state_q <= StFetch;
          StFetch: ;
          StDrain: begin
            if (rsp_fire) begin
              discard_q <= discard_q - CW'(1);
              if (discard_q == CW'(1)) state_q <= StFetch;
            end
          end
          default: state_q <= StBoot;
        endcase
      end
    end
  end

  assert property (@(posedge clk) disable iff (!reset_n) !(irvalid && (outstanding_q == '0)))
    else $error("instr_fetch: irvalid with no outstanding request");

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, instruction buffer entries; legal values 2 or 4.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 iaddr  output  32  instruction memory request address, word-aligned.
REQ-006 ireq  output  1  request valid; a request transfers when ireq and igrant are both high.
REQ-007 igrant  input  1  memory accepts the request this cycle.
REQ-008 irvalid  input  1  response valid; responses return in request order, latency of 1 or more cycles.
REQ-009 irdata  input  32  response instruction word.
REQ-010 redir_valid  input  1  branch/jump redirect from execute; one-cycle pulse.
REQ-011 redir_pc  input  32  redirect target.
REQ-012 out_valid  output  1  instruction available to decode/immediate-generation stage.
REQ-013 out_ready  input  1  decode accepts; a transfer occurs when out_valid and out_ready are both high.
REQ-014 out_instr  output  32  fetched instruction word.
REQ-015 out_pc  output  32  address of out_instr.

Function
REQ-016 The PC register shall advance by 4 on each accepted request and wrap from 32'hFFFF_FFFC to 32'h0000_0000.
REQ-017 redir_pc[1:0] shall be ignored; the target is {redir_pc[31:2],2'b00}.
REQ-018 Credit rule: ireq shall be high only when outstanding requests plus buffer occupancy are less than BUF_DEPTH, the FSM is in FETCH, and redir_valid is low.
REQ-019 iaddr shall equal the PC register and hold stable while ireq is high and igrant is low.
REQ-020 Each non-discarded response shall be written into the buffer with its PC, taken from an in-order PC queue of BUF_DEPTH entries.
REQ-021 The buffer head shall drive out_valid, out_instr, and out_pc combinationally; the head shall pop on transfer.
REQ-022 Minimum latency shall be one cycle from irvalid to out_valid, with an empty buffer.
REQ-023 Simultaneous push and pop on a full buffer shall be legal and shall not lose data.
REQ-024 FSM states shall be BOOT, FETCH, and DRAIN; BOOT goes to FETCH on the first cycle after reset deassertion.
REQ-025 On redir_valid: flush the buffer, load the PC with the target, set the discard count to the outstanding count, and enter DRAIN if the count is nonzero, otherwise FETCH.
REQ-026 DRAIN shall drop each irvalid and decrement the discard count; it shall enter FETCH when the count reaches 0, with ireq allowed that same cycle.
REQ-027 A response arriving in the redirect cycle shall be discarded and counted against the discard count.
REQ-028 A redirect during DRAIN shall reload the PC and keep discarding; the discard count equals the total outstanding requests.
REQ-029 out_valid shall be low in the redirect cycle and in every cycle the buffer is empty.
REQ-030 A redirect and an out transfer in the same cycle: the redirect wins, and no transfer occurs.
REQ-031 irvalid with zero outstanding requests is a protocol error: ignore it; a simulation assertion shall fire.

Reset
REQ-032 While reset_n is low: PC=RESET_PC, state=BOOT, buffer empty, outstanding=0, discard=0, ireq=0, out_valid=0, iaddr=RESET_PC, out_instr=32'h0000_0013 (NOP), out_pc=32'h0.
REQ-033 Reset asserted mid-operation shall abandon outstanding requests; their later responses are the memory model's responsibility.

Structure
REQ-034 The shared package shall hold RESET_PC default, NOP_INSTR=32'h0000_0013, the FSM state enum, and the XLEN=32 constant.
REQ-035 The buffer shall be a sub-module fetch_fifo (parameter DEPTH, width 64 = {pc,instr}, with push, pop, flush, full, empty, and count).

Verification
REQ-036 After reset release, igrant=1 and 1-cycle response: out_pc sequence 0x0,0x4,0x8 with matching irdata, first out_valid on cycle 3.
REQ-037 out_ready=0 for 10 cycles: ireq deasserts after 2 grants, there is no overflow, and on release the order 0x0,0x4 is preserved.
REQ-038 Redirect to 0x103 with 2 outstanding: the next iaddr is 0x100, two responses are dropped, and the first out_pc is 0x100.
REQ-039 Redirect then redirect again during DRAIN to 0x200: only 0x200-stream instructions appear at out_pc.
REQ-040 PC=0xFFFF_FFFC fetch: the next iaddr is 0x0000_0000.
REQ-041 reset_n pulsed low mid-stream with 2 outstanding: outputs reach reset values immediately, and the fetch restarts at RESET_PC.
